// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-input valid/ready stream multiplexer with round-robin arbitration.
// A granted channel owns the single registered output stage until it sends its last beat.
module rr_stream_mux #(
  parameter int WIDTH  = 4,
  parameter int INPUTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*INPUTS-1:0] in_data,
  input  logic [INPUTS-1:0]       in_valid,
  input  logic [INPUTS-1:0]       in_last,
  output logic [INPUTS-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [INPUTS-1:0]       grant
);
  localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  ptr_nxt_s;
  logic [PTR_W-1:0]  owner_r;
  logic [PTR_W-1:0]  owner_nxt_s;
  logic [INPUTS-1:0] sel_s;
  logic [PTR_W-1:0]  sel_idx_s;
  logic              hit_s;
  logic              accept_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  data_r;
  logic              valid_r;
  logic              last_r;

  // Channel selection: the locked owner only, or the first valid channel after ptr.
  always_comb begin
    sel_s     = {INPUTS{1'b0}};
    sel_idx_s = {PTR_W{1'b0}};
    hit_s     = 1'b0;
    if (rst) begin
      hit_s = 1'b0;
    end else if (state_r == ST_LOCKED) begin
      sel_idx_s = owner_r;
      hit_s     = in_valid[owner_r];
    end else begin
      for (int k = 1; k <= INPUTS; k++) begin
        if (!hit_s && in_valid[PTR_W'((int'(ptr_r) + k) % INPUTS)]) begin
          sel_idx_s = PTR_W'((int'(ptr_r) + k) % INPUTS);
          hit_s     = 1'b1;
        end else begin
          hit_s = hit_s;
        end
      end
    end
    if (hit_s) begin
      sel_s[sel_idx_s] = 1'b1;
    end else begin
      sel_s = {INPUTS{1'b0}};
    end
  end

  // The output register can take a beat when empty or being drained this cycle.
  assign accept_s  = !valid_r || out_ready;
  assign xfer_s    = hit_s && accept_s;
  assign grant     = sel_s;
  assign in_ready  = sel_s & {INPUTS{accept_s}};
  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;

  // Next lock state: a last beat frees the output and moves the pointer past the sender.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    owner_nxt_s = owner_r;
    if (xfer_s) begin
      case (in_last[sel_idx_s])
        1'b1: begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = sel_idx_s;
        end
        1'b0: begin
          state_nxt_s = ST_LOCKED;
          owner_nxt_s = sel_idx_s;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Arbitration state register; reset leaves channel 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTR_W'(INPUTS - 1);
      owner_r <= {PTR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  // Output stage: load on transfer, empty on drain without a new beat, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      last_r  <= 1'b0;
    end else if (xfer_s) begin
      valid_r <= 1'b1;
      data_r  <= in_data[sel_idx_s*WIDTH +: WIDTH];
      last_r  <= in_last[sel_idx_s];
    end else if (accept_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule
